// File: rtl/lut_chain_serial_cfg.sv
// Chain of fracturable sub-LUTs configured through a daisy-chained scan register with atomic commit.
// Latency 0 from addr (1 cycle when LUT_CHAIN_OUTREG_EN is defined); shifting never disturbs active outputs.
// No backpressure: one config bit accepted per enabled cycle, illegal loads set a sticky error.
module lut_chain_serial_cfg #(
   parameter int INPUTS   = 4,
   parameter int NUM_LUTS = 2
) (
   input  logic                         config_clk,
   input  logic                         config_rst_n,
   input  logic [NUM_LUTS*INPUTS-1:0]   addr,
   output logic [NUM_LUTS-1:0]          out,
   input  logic                         config_en,
   input  logic                         config_in,
   output logic                         config_out,
   input  logic                         config_load,
   output logic                         config_done,
   output logic                         config_err
);

   localparam int MEM_SIZE = 2**INPUTS;
   localparam int CFG_BITS = NUM_LUTS*MEM_SIZE + NUM_LUTS - 1;
   localparam int CW       = $clog2(CFG_BITS + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(CFG_BITS);

   logic [CFG_BITS-1:0] r_shadow;
   logic [CFG_BITS-1:0] r_active;
   logic [CW-1:0]       r_cnt;
   logic                r_done;
   logic                r_err;
   logic [NUM_LUTS-1:0] w_out_c;
   logic                w_commit;

   assign w_commit = config_load && !config_en && (r_cnt == FULL_CNT);

   always_ff @(posedge config_clk or negedge config_rst_n) begin
      if (!config_rst_n) begin
         r_shadow <= '0;
         r_active <= '0;
         r_cnt    <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         if (config_en) begin
            r_shadow <= {config_in, r_shadow[CFG_BITS-1:1]};
            if (r_cnt != FULL_CNT)
               r_cnt <= r_cnt + CW'(1);
         end
         // A rejected load still lets a simultaneous shift proceed.
         if (w_commit) begin
            r_active <= r_shadow;
            r_cnt    <= '0;
            r_done   <= 1'b1;
            r_err    <= 1'b0;
         end else if (config_load) begin
            r_err    <= 1'b1;
         end
      end
   end

   assign config_out  = r_shadow[0];
   assign config_done = r_done;
   assign config_err  = r_err;

   // Each stage keeps its own output net so the ripple cascade is not a self-loop on one vector.
   for (genvar i = 0; i < NUM_LUTS; i++) begin : g_lut
      logic [MEM_SIZE-1:0] w_tbl;
      logic [INPUTS-1:0]   w_idx;
      logic                w_o;

      assign w_tbl = r_active[i*MEM_SIZE +: MEM_SIZE];

      if (i == 0) begin : g_first
         assign w_idx = addr[INPUTS-1:0];
      end else begin : g_next
         assign w_idx = {r_active[NUM_LUTS*MEM_SIZE + i - 1] ? addr[i*INPUTS + INPUTS - 1]
                                                              : g_lut[i-1].w_o,
                         addr[i*INPUTS +: INPUTS-1]};
      end

      assign w_o        = w_tbl[w_idx];
      assign w_out_c[i] = w_o;
   end

`ifdef LUT_CHAIN_OUTREG_EN
   logic [NUM_LUTS-1:0] r_out;

   always_ff @(posedge config_clk or negedge config_rst_n) begin
      if (!config_rst_n)
         r_out <= '0;
      else
         r_out <= w_out_c;
   end

   assign out = r_out;
`else
   assign out = w_out_c;
`endif

endmodule

// File: tb/tb_lut_chain_serial_cfg.sv
// Bench for lut_chain_serial_cfg with INPUTS=2, NUM_LUTS=2 (9 config bits).
module tb_lut_chain_serial_cfg;

   localparam logic [8:0] CFG_A = 9'b1_0110_1000;  // frac=1, LUT1=XOR, LUT0=AND
   localparam logic [8:0] CFG_B = 9'b0_0110_1000;  // same tables, cascaded

   typedef struct {
      logic [3:0] addr;
      logic [1:0] exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] addr;
   logic [1:0] out;
   logic       cfg_en, cfg_in, cfg_out, cfg_load, cfg_done, cfg_err;

   int         n_vec = 0;
   int         n_err = 0;
   logic [8:0] sh;
   logic [1:0] sb_q[$];
   vec_t       vec_a[6];
   vec_t       vec_b[8];

   always #5 clk = ~clk;

   lut_chain_serial_cfg #(.INPUTS(2), .NUM_LUTS(2)) dut (
      .config_clk   (clk),
      .config_rst_n (rst_n),
      .addr         (addr),
      .out          (out),
      .config_en    (cfg_en),
      .config_in    (cfg_in),
      .config_out   (cfg_out),
      .config_load  (cfg_load),
      .config_done  (cfg_done),
      .config_err   (cfg_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic run_vec(input string name, input logic [3:0] a, input logic [1:0] e);
      logic [1:0] exp_pop;
      @(negedge clk);
      addr = a;
      sb_q.push_back(e);
`ifdef LUT_CHAIN_OUTREG_EN
      @(posedge clk);
`endif
      #1;
      exp_pop = sb_q.pop_front();
      check(name, out, exp_pop);
   endtask

   task automatic shift_bits(input logic [8:0] bits, input int lo, input int hi,
                             input logic chk_hold, input logic [1:0] hold_exp);
      for (int k = lo; k <= hi; k++) begin
         @(negedge clk);
         if (chk_hold) begin
            check("hold_out", out, hold_exp);
            check("cfg_out_replay", cfg_out, sh[0]);
         end
         cfg_en = 1'b1;
         cfg_in = bits[k];
         sh     = {bits[k], sh[8:1]};
      end
      @(negedge clk);
      cfg_en = 1'b0;
   endtask

   task automatic load_pulse(input logic with_en, input logic cin);
      @(negedge clk);
      cfg_load = 1'b1;
      cfg_en   = with_en;
      cfg_in   = cin;
      if (with_en) sh = {cin, sh[8:1]};
      @(negedge clk);
      cfg_load = 1'b0;
      cfg_en   = 1'b0;
   endtask

   initial begin
      vec_a[0] = '{4'b0000, 2'b00};
      vec_a[1] = '{4'b0011, 2'b01};
      vec_a[2] = '{4'b1111, 2'b01};
      vec_a[3] = '{4'b0111, 2'b11};
      vec_a[4] = '{4'b1001, 2'b10};
      vec_a[5] = '{4'b0100, 2'b10};

      vec_b[0] = '{4'b0111, 2'b01};
      vec_b[1] = '{4'b1111, 2'b01};
      vec_b[2] = '{4'b0011, 2'b11};
      vec_b[3] = '{4'b1011, 2'b11};
      vec_b[4] = '{4'b0100, 2'b10};
      vec_b[5] = '{4'b1100, 2'b10};
      vec_b[6] = '{4'b0000, 2'b00};
      vec_b[7] = '{4'b1000, 2'b00};

      rst_n = 1'b0; addr = 4'b1111; cfg_en = 1'b0; cfg_in = 1'b0; cfg_load = 1'b0; sh = '0;
      repeat (3) @(negedge clk);
      check("rst_out", out, 2'b00);
      check("rst_done", cfg_done, 1'b0);
      check("rst_err", cfg_err, 1'b0);
      check("rst_cfg_out", cfg_out, 1'b0);
      rst_n = 1'b1;
      run_vec("empty_out", 4'b1111, 2'b00);

      shift_bits(CFG_A, 0, 8, 1'b0, 2'b00);
      load_pulse(1'b0, 1'b0);
      check("a_done", cfg_done, 1'b1);
      check("a_err", cfg_err, 1'b0);
      for (int i = 0; i < 6; i++) run_vec("frac_vec", vec_a[i].addr, vec_a[i].exp);

      shift_bits(CFG_B, 0, 8, 1'b0, 2'b00);
      load_pulse(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) run_vec("cascade_vec", vec_b[i].addr, vec_b[i].exp);

      run_vec("pre_reject", 4'b0011, 2'b11);
      shift_bits(CFG_A, 0, 4, 1'b1, 2'b11);
      load_pulse(1'b0, 1'b0);
      check("short_load_err", cfg_err, 1'b1);
      check("short_load_done", cfg_done, 1'b1);
      check("short_load_out", out, 2'b11);
      shift_bits(CFG_A, 5, 8, 1'b1, 2'b11);
      load_pulse(1'b0, 1'b0);
      check("full_load_err", cfg_err, 1'b0);
      run_vec("full_load_out", 4'b0011, 2'b01);

      // Active stays on CFG_A while CFG_B streams in; config_out replays CFG_A.
      shift_bits(CFG_B, 0, 8, 1'b1, 2'b01);
      check("loaded_shift_done", cfg_done, 1'b1);
      check("loaded_shift_out", out, 2'b01);
      load_pulse(1'b0, 1'b0);
      run_vec("reload_out", 4'b0011, 2'b11);

      // Shift together with load: rejected, but the extra bit still enters and the commit
      // after saturation takes the last nine bits {0, CFG_A[8:1]}.
      shift_bits(CFG_A, 0, 8, 1'b1, 2'b11);
      load_pulse(1'b1, 1'b0);
      check("en_load_err", cfg_err, 1'b1);
      check("en_load_out", out, 2'b11);
      load_pulse(1'b0, 1'b0);
      check("sat_load_err", cfg_err, 1'b0);
      run_vec("sat_vec0", 4'b0010, 2'b01);
      run_vec("sat_vec1", 4'b0000, 2'b10);

`ifdef LUT_CHAIN_OUTREG_EN
      run_vec("reg_base", 4'b0010, 2'b01);
      @(negedge clk);
      addr = 4'b0000;
      #1 check("reg_before_edge", out, 2'b01);
      @(posedge clk);
      #1 check("reg_after_edge", out, 2'b10);
`endif

      shift_bits(CFG_A, 0, 8, 1'b0, 2'b00);
      @(negedge clk);
      cfg_load = 1'b1;
      #3 rst_n = 1'b0;
      #1;
      sh = '0;
      check("async_rst_out", out, 2'b00);
      check("async_rst_done", cfg_done, 1'b0);
      check("async_rst_err", cfg_err, 1'b0);
      check("async_rst_cfg_out", cfg_out, 1'b0);
      @(negedge clk);
      rst_n    = 1'b1;
      cfg_load = 1'b0;
      check("commit_discarded", cfg_done, 1'b0);
      run_vec("post_rst_out", 4'b1111, 2'b00);

      shift_bits(CFG_A, 0, 3, 1'b0, 2'b00);
      load_pulse(1'b0, 1'b0);
      check("partial_err", cfg_err, 1'b1);
      check("partial_done", cfg_done, 1'b0);
      check("partial_out", out, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/lut_chain_serial_cfg.md
Name: lut_chain_serial_cfg

Overview:
- Parametrised successor to the two-way fracturable LUT.
- NUM_LUTS sub-LUTs, each with INPUTS inputs; every adjacent pair is independently fractured or cascaded by a mode bit.
- Configuration is loaded serially through a daisy-chainable scan register, then committed atomically into an active register by an explicit load pulse. Outputs never glitch while a new bitstream is shifting.
- Sits in the CLB as the logic element; config_in/config_out thread the per-tile configuration chain.

Parameters:
- INPUTS, 4, address inputs per sub-LUT (>=2).
- NUM_LUTS, 2, number of sub-LUTs (>=2).
- MEM_SIZE, 2**INPUTS, truth-table bits per sub-LUT (derived; do not override).
- CFG_BITS, NUM_LUTS*MEM_SIZE+NUM_LUTS-1, total configuration bits (derived).

Ports:
- config_clk  in  1  configuration and output-register clock.
- config_rst_n  in  1  asynchronous active-low reset.
- addr  in  NUM_LUTS*INPUTS  addr[i*INPUTS +: INPUTS] belongs to sub-LUT i.
- out  out  NUM_LUTS  out[i] is the output of sub-LUT i.
- config_en  in  1  shift enable: one config bit per cycle.
- config_in  in  1  serial configuration data in.
- config_out  out  1  serial data out to the next tile.
- config_load  in  1  commit pulse: shadow register to active register.
- config_done  out  1  active register holds a committed bitstream.
- config_err  out  1  sticky error: load rejected.

Behaviour:
- Reset (async, config_rst_n=0):
  - shadow, active, bit counter, config_done, config_err all cleared to 0.
  - out=0 (all truth tables 0); config_out=0.
- Shift: when config_en=1 on a config_clk edge:
  - shadow <= {config_in, shadow[CFG_BITS-1:1]}.
  - config_out = shadow[0] (registered, so there is one bit of delay per tile).
  - Bit counter increments and saturates at CFG_BITS.
- Bit ordering: the first bit shifted in lands at shadow[0] after CFG_BITS shifts.
  - Active bits [i*MEM_SIZE +: MEM_SIZE] are the table of sub-LUT i, indexed by its address.
  - Bit NUM_LUTS*MEM_SIZE+j is the mode bit frac[j] for the boundary between sub-LUTs j and j+1.
- States, derived from counter and flags:
  - EMPTY: config_done=0, counter=0.
  - SHIFTING: counter>0.
  - FULL: counter=CFG_BITS.
  - LOADED: config_done=1. Shifting in LOADED moves to SHIFTING/FULL while config_done stays 1 and outputs keep using the old active value.
- Commit: config_load=1 and config_en=0 and counter=CFG_BITS.
  - Next edge: active <= shadow, counter <= 0, config_done <= 1, config_err <= 0.
  - New outputs are visible combinationally after that edge.
- Rejected load: config_load=1 with counter<CFG_BITS, or config_load=1 together with config_en=1.
  - active is unchanged and config_err <= 1 (sticky).
  - If config_en was also 1, the shift still occurs.
- Counter saturation: extra shifts beyond CFG_BITS keep shifting, and a later commit takes the last CFG_BITS bits. This supports pass-through of downstream tiles' bits.
- Evaluation: sub-LUT 0 uses addr[INPUTS-1:0]. For i>0:
  - Low INPUTS-1 bits come from its own slice.
  - MSB = frac[i-1] ? addr[i*INPUTS+INPUTS-1] : out_c[i-1].
  - This is a ripple cascade; with all frac=0, NUM_LUTS sub-LUTs form a single chained function.
- Latency: 0 cycles (combinational from addr) unless the optional feature is enabled.
- Reset mid-shift or mid-commit:
  - Everything clears and any partial bitstream is lost.
  - A commit on the same edge as reset assertion is discarded.

Optional Feature:
- Macro: LUT_CHAIN_OUTREG_EN.
- Defined: every out[i] is registered on config_clk, giving 1-cycle latency from addr. The register resets to 0 asynchronously and is updated every cycle regardless of config_en. Cascade feedback to the next sub-LUT uses the combinational out_c[i-1], not the registered value.
- Undefined: out is purely combinational, with no flops.

Test Plan:
- INPUTS=2, NUM_LUTS=2 (CFG_BITS=9): reset, then drive any addr -> out=0, config_done=0, config_err=0, config_out=0.
- Shift 9 bits for tables LUT0=4'b1000 (AND), LUT1=4'b0110 (XOR), frac[0]=1, then pulse config_load -> config_done=1.
  - addr=4'b11_11 -> out=2'b01.
  - addr=4'b01_11 -> out=2'b11.
- Same tables with frac[0]=0, then addr={x,1,1,1} -> LUT1 MSB=out[0]=1 and low bit=1, so out[1]=0.
  - Changing addr[3] has no effect on out.
- After commit, shift 5 new bits then pulse config_load -> config_err=1 and out unchanged.
  - Then shift 4 more bits and load -> config_err=0 and the new tables are active.
- While LOADED, shift a full 9-bit stream with config_load low -> out unchanged every cycle.
  - config_out replays the previous shadow contents bit-by-bit, 1 cycle per bit.
- With LUT_CHAIN_OUTREG_EN: addr change -> out updates exactly 1 config_clk edge later.
  - Assert config_rst_n=0 asynchronously mid-cycle -> out=0 immediately.
